// File: rtl/bus_if_types_pkg.sv
// ---------------------------------------------------------------------------
// bus_if_types_pkg
// Shared bus-interface types: transfer type and size encodings used by the
// ibus/dbus masters and the shared slave port, plus the bus_arb state and
// owner encodings.
// ---------------------------------------------------------------------------
package bus_if_types_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_e;

    // Arbiter state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_GNT_M0 = 2'd1;
    localparam arb_state_t ARB_GNT_M1 = 2'd2;

    // Owner encoding for last_owner
    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/bus_arb.sv
// ---------------------------------------------------------------------------
// bus_arb
// Two-master arbiter in front of a single shared slave port.
//   m0_* : instruction-fetch master (ibus)
//   m1_* : load/store master (dbus)
//   s_*  : shared slave port
// Per master: breq/bstart/ttype/tsize/addr/wdata in; bdone/rdata/gnt out.
// Slave side: breq/bstart/ttype/tsize/addr/wdata out; bdone/rdata in.
// clk rising edge; rst_n asynchronous, active-low.
//
// While a master owns the port the slave outputs follow that master's fields
// combinationally. Every grant is followed by at least one IDLE cycle.
//
// Configuration macro: BUS_ARB_RR_EN
//   defined   : simultaneous requests resolved round-robin on last_owner
//   undefined : fixed priority, m1 (dbus) wins ties
// ---------------------------------------------------------------------------
module bus_arb
    import bus_if_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // ibus master
    input  logic              m0_breq,
    input  logic              m0_bstart,
    input  ttype_e            m0_ttype,
    input  tsize_e            m0_tsize,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_bdone,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_gnt,
    // dbus master
    input  logic              m1_breq,
    input  logic              m1_bstart,
    input  ttype_e            m1_ttype,
    input  tsize_e            m1_tsize,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_bdone,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_gnt,
    // shared slave port
    output logic              s_breq,
    output logic              s_bstart,
    output ttype_e            s_ttype,
    output tsize_e            s_tsize,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_bdone,
    input  logic [DATA_W-1:0] s_rdata
);

    arb_state_t state, nxt_state;
    logic       last_owner;
    logic       tie_pick_m0;

`ifdef BUS_ARB_RR_EN
    // Round-robin: on a tie, the master that did not own the port last wins
    assign tie_pick_m0 = (last_owner == OWN_M1);
`else
    // Fixed priority: dbus always wins ties; last_owner is kept but not consumed
    logic unused_last_owner;
    assign tie_pick_m0       = 1'b0;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        nxt_state = state;
        case (state)
            ARB_IDLE: begin
                if (m0_bstart && m1_bstart)
                    nxt_state = tie_pick_m0 ? ARB_GNT_M0 : ARB_GNT_M1;
                else if (m0_bstart)
                    nxt_state = ARB_GNT_M0;
                else if (m1_bstart)
                    nxt_state = ARB_GNT_M1;
            end
            ARB_GNT_M0: if (s_bdone || !m0_bstart) nxt_state = ARB_IDLE;
            ARB_GNT_M1: if (s_bdone || !m1_bstart) nxt_state = ARB_IDLE;
            default:    nxt_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_owner <= OWN_M1;
        end else begin
            state <= nxt_state;
            if (state == ARB_GNT_M0 && nxt_state == ARB_IDLE) last_owner <= OWN_M0;
            if (state == ARB_GNT_M1 && nxt_state == ARB_IDLE) last_owner <= OWN_M1;
        end
    end

    // Output mux. bdone is additionally qualified by the owner's bstart so an
    // abandoned transfer never reports completion.
    always_comb begin
        s_breq   = 1'b0;
        s_bstart = 1'b0;
        s_ttype  = READ;
        s_tsize  = WORD;
        s_addr   = '0;
        s_wdata  = '0;
        m0_gnt   = 1'b0;
        m0_bdone = 1'b0;
        m0_rdata = '0;
        m1_gnt   = 1'b0;
        m1_bdone = 1'b0;
        m1_rdata = '0;
        case (state)
            ARB_GNT_M0: begin
                s_breq   = m0_breq;
                s_bstart = m0_bstart;
                s_ttype  = m0_ttype;
                s_tsize  = m0_tsize;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                m0_gnt   = 1'b1;
                m0_bdone = s_bdone & m0_bstart;
                m0_rdata = s_rdata;
            end
            ARB_GNT_M1: begin
                s_breq   = m1_breq;
                s_bstart = m1_bstart;
                s_ttype  = m1_ttype;
                s_tsize  = m1_tsize;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                m1_gnt   = 1'b1;
                m1_bdone = s_bdone & m1_bstart;
                m1_rdata = s_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_bus_arb
// Directed testbench for bus_arb with hand-computed expectations.
// Tie-break expectations follow BUS_ARB_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_bus_arb;
    import bus_if_types_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m0_breq = 0, m0_bstart = 0;
    ttype_e            m0_ttype = READ;
    tsize_e            m0_tsize = WORD;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m0_bdone, m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_breq = 0, m1_bstart = 0;
    ttype_e            m1_ttype = READ;
    tsize_e            m1_tsize = WORD;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m1_bdone, m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_breq, s_bstart;
    ttype_e            s_ttype;
    tsize_e            s_tsize;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_bdone = 0;
    logic [DATA_W-1:0] s_rdata = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bdone(m0_bdone), .m0_rdata(m0_rdata), .m0_gnt(m0_gnt),
        .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bdone(m1_bdone), .m1_rdata(m1_rdata), .m1_gnt(m1_gnt),
        .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_bdone(s_bdone), .s_rdata(s_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m0_breq = 0; m0_bstart = 0; m1_breq = 0; m1_bstart = 0;
        s_bdone = 0; s_rdata = '0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // ---------------- reset state
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_s_bstart", s_bstart, 0);
        check("rst_s_breq",   s_breq,   0);
        check("rst_s_ttype",  s_ttype,  READ);
        check("rst_s_tsize",  s_tsize,  WORD);
        check("rst_s_addr",   s_addr,   0);
        check("rst_gnts",     {m0_gnt, m1_gnt}, 2'b00);
        #2;
        rst_n = 1'b1;
        step();

        // ---------------- single M0 read, 1-cycle latency
        m0_breq = 1; m0_bstart = 1; m0_addr = 32'h100; m0_ttype = READ; m0_tsize = WORD;
        #1;
        check("m0rd_lat0_bstart", s_bstart, 0);
        step();
        check("m0rd_s_bstart", s_bstart, 1);
        check("m0rd_s_addr",   s_addr,   32'h100);
        check("m0rd_gnts",     {m0_gnt, m1_gnt}, 2'b10);
        s_bdone = 1; s_rdata = 32'hDEADBEEF;
        #1;
        check("m0rd_m0_bdone", m0_bdone, 1);
        check("m0rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("m0rd_m1_bdone", m1_bdone, 0);
        check("m0rd_m1_rdata", m1_rdata, 0);
        step();
        m0_breq = 0; m0_bstart = 0; s_bdone = 0;
        #1;
        check("m0rd_idle_gnts", {m0_gnt, m1_gnt}, 2'b00);

        // ---------------- ties over 4 transfers
        do_reset();
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_bstart = 1; m1_bstart = 1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
`ifdef BUS_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            step();
            check($sformatf("tie%0d_gnts", i), {m0_gnt, m1_gnt}, exp_g);
            check($sformatf("tie%0d_addr", i), s_addr, exp_g[1] ? 32'h10 : 32'h20);
            s_bdone = 1;
            #1;
            check($sformatf("tie%0d_bdone", i), {m0_bdone, m1_bdone}, exp_g);
            step();
            s_bdone = 0;
            #1;
            check($sformatf("tie%0d_idle", i), {m0_gnt, m1_gnt, s_bstart}, 3'b000);
        end
        m0_bstart = 0; m1_bstart = 0;
        step();

        // ---------------- M1 byte write while M0 waits
        m1_bstart = 1; m1_breq = 1; m1_ttype = WRITE; m1_tsize = BYTE;
        m1_addr = 32'h2000; m1_wdata = 32'h55;
        step();
        m0_bstart = 1; m0_addr = 32'h300; m0_ttype = READ; m0_tsize = WORD;
        #1;
        check("wr_ttype", s_ttype, WRITE);
        check("wr_tsize", s_tsize, BYTE);
        check("wr_wdata", s_wdata, 32'h55);
        check("wr_addr",  s_addr,  32'h2000);
        check("wr_gnts",  {m0_gnt, m1_gnt}, 2'b01);
        step();
        check("wr_stall_gnts", {m0_gnt, m1_gnt}, 2'b01);
        s_bdone = 1;
        step();
        m1_bstart = 0; m1_breq = 0; s_bdone = 0;
        #1;
        check("wr_idle_gnts", {m0_gnt, m1_gnt}, 2'b00);
        step();
        check("wr_m0_gnts", {m0_gnt, m1_gnt}, 2'b10);
        check("wr_m0_addr", s_addr, 32'h300);
        s_bdone = 1;
        step();
        m0_bstart = 0; s_bdone = 0;
        step();

        // ---------------- reset during stalled M0 transfer
        m0_bstart = 1; m0_addr = 32'h400;
        step();
        check("rstx_gnt", m0_gnt, 1);
        #2;
        rst_n = 0;
        s_bdone = 1;
        #1;
        check("rstx_s_bstart", s_bstart, 0);
        check("rstx_bdone",    {m0_bdone, m1_bdone, m0_gnt}, 3'b000);
        m0_bstart = 0; s_bdone = 0;
        #2;
        rst_n = 1;
        step();
        m0_bstart = 1;
        #1;
        check("rstx_lat0", s_bstart, 0);
        step();
        check("rstx_lat1",  s_bstart, 1);
        check("rstx_addr",  s_addr, 32'h400);
        s_bdone = 1;
        step();
        m0_bstart = 0; s_bdone = 0;
        step();

        // ---------------- spurious s_bdone in IDLE
        s_bdone = 1; s_rdata = 32'h1234;
        #1;
        check("spur_bdone", {m0_bdone, m1_bdone}, 2'b00);
        check("spur_rdata", {m0_rdata, m1_rdata}, 64'h0);
        step();
        s_bdone = 0;
        #1;
        check("spur_idle", {m0_gnt, m1_gnt, s_bstart}, 3'b000);

        // ---------------- M1 abandons before s_bdone, M0 pending
        m1_bstart = 1; m1_addr = 32'h500;
        step();
        check("drop_m1_gnt", m1_gnt, 1);
        m0_bstart = 1; m0_addr = 32'h600;
        step();
        m1_bstart = 0;
        #1;
        check("drop_s_bstart", s_bstart, 0);
        check("drop_no_bdone", m1_bdone, 0);
        step();
        check("drop_idle", {m0_gnt, m1_gnt, s_bstart}, 3'b000);
        step();
        check("drop_m0_gnts", {m0_gnt, m1_gnt}, 2'b10);
        check("drop_m0_addr", s_addr, 32'h600);
        s_bdone = 1;
        step();
        m0_bstart = 0; s_bdone = 0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_breq, m0_bstart  in  1 each  instruction-fetch master (ibus) request and transfer start; bstart held until bdone.
REQ-006 m0_ttype  in  ttype_e; m0_tsize  in  tsize_e; m0_addr  in  ADDR_W; m0_wdata  in  DATA_W  ibus transfer fields.
REQ-007 m0_bdone  out  1; m0_rdata  out  DATA_W; m0_gnt  out  1  ibus completion, read data, grant.
REQ-008 m1_* (same set as m0_*)  in/out  same widths  load/store master (dbus).
REQ-009 s_breq, s_bstart  out  1; s_ttype, s_tsize, s_addr, s_wdata  out  per field  shared slave port.
REQ-010 s_bdone  in  1; s_rdata  in  DATA_W  slave completion pulse and read data.

Function
REQ-011 FSM states: IDLE, GNT_M0, GNT_M1.
REQ-012 Transitions: IDLE to GNT_Mx when mx_bstart=1 and mx wins arbitration; GNT_Mx to IDLE when s_bdone=1 or mx_bstart=0.
REQ-013 Arbitration latency: 1 cycle from mx_bstart sampled high in IDLE to s_bstart high.
REQ-014 While in GNT_Mx: s_* outputs combinationally equal mx_* fields; mx_gnt=1.
REQ-015 While in IDLE: s_breq, s_bstart, s_addr, s_wdata = 0; s_ttype = READ; s_tsize = WORD.
REQ-016 s_bdone is routed only to the owner's mx_bdone in the same cycle; the non-owner's bdone = 0.
REQ-017 s_rdata is routed only to the owner's mx_rdata; the non-owner's rdata = 0.
REQ-018 s_bdone in IDLE is ignored; no master sees bdone.
REQ-019 At least one IDLE cycle separates consecutive grants (no back-to-back chaining).
REQ-020 Owner dropping bstart before s_bdone: return to IDLE next cycle; s_bstart low from that cycle; no bdone forwarded.
REQ-021 A request arriving while the other master owns the port waits; its bstart is held and no field is sampled.
REQ-022 Register last_owner (1 bit) is updated to x on each GNT_Mx to IDLE transition.

Reset
REQ-023 Asynchronous reset forces state=IDLE and last_owner=M1 immediately; all outputs take their IDLE values during reset.
REQ-024 Reset mid-transfer drops s_bstart without bdone; no transfer state is retained.

Configuration
REQ-025 Macro BUS_ARB_RR_EN defined: on simultaneous bstart in IDLE, grant the master that is not last_owner (round-robin).
REQ-026 Macro BUS_ARB_RR_EN undefined: fixed priority, M1 (dbus) always wins ties; last_owner is still maintained but unused.
REQ-027 Single request in IDLE: granted in either configuration.

Structure
REQ-028 ttype_e and tsize_e come from bus_if_types_pkg; the arbiter state enum and owner encoding are added to that package.
REQ-029 Single flat module with no sub-module; the round-robin select is inline logic.

Verification
REQ-030 After reset, m0_bstart=1 with addr 0x100 READ: s_bstart high at cycle 2, s_addr=0x100; s_bdone with rdata 0xDEADBEEF gives m0_bdone=1, m0_rdata=0xDEADBEEF, m1_bdone=0.
REQ-031 Both bstart high with BUS_ARB_RR_EN defined: grant order is M0, M1, M0, M1 over 4 transfers; with the macro undefined, M1 wins every tie.
REQ-032 M1 WRITE to 0x2000, wdata 0x55, tsize BYTE, while M0 requests: s_ttype=WRITE, s_tsize=BYTE, s_wdata=0x55; M0 granted only after an IDLE cycle following s_bdone.
REQ-033 Assert rst_n=0 during GNT_M0 with the slave stalled: s_bstart=0 immediately; after release, a fresh M0 request re-arbitrates with 1-cycle latency.
REQ-034 Spurious s_bdone in IDLE: both mx_bdone stay 0 and the state stays IDLE.
REQ-035 Owner M1 drops bstart before s_bdone: state is IDLE the next cycle, then pending M0 is granted the following cycle.
